// File: rtl/ptw_mem_responder_if.sv
// Walker PTE-read port, data-bus read port, flush and busy status for ptw_mem_responder.
// slave is the responder's view; master is the walker/bus side.
interface ptw_mem_responder_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic        mem_data_valid;
    logic        flush;
    logic        bus_valid;
    logic [63:0] bus_addr;
    logic [2:0]  bus_size;
    logic        bus_data_ok;
    logic [63:0] bus_data;
    logic        busy;

    modport slave (
        input  mem_req, mem_addr, flush, bus_data_ok, bus_data,
        output mem_data, mem_data_valid, bus_valid, bus_addr, bus_size, busy
    );

    modport master (
        output mem_req, mem_addr, flush, bus_data_ok, bus_data,
        input  mem_data, mem_data_valid, bus_valid, bus_addr, bus_size, busy
    );
endinterface

// File: rtl/ptw_mem_responder.sv
// PTE-read responder for the page-table walker: one outstanding 8-byte bus read per request.
// Optional direct-mapped PTE cache built when PTW_PTE_CACHE_EN is defined.
module ptw_mem_responder #(
    parameter int unsigned CACHE_ENTRIES = 4
) (
    input logic                 clk,
    input logic                 reset,
    ptw_mem_responder_if.slave  pte_io
);

    typedef enum logic [1:0] {StIdle, StLookup, StBus, StResp} state_e;

    state_e      state_q, state_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [63:0] mem_data_q, mem_data_d;
    logic        drop_q, drop_d;
    logic        nofill_q, nofill_d;
    logic        hit;
    logic [63:0] hit_pte;
    logic        flush_in;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^pte_io.mem_addr[2:0];

`ifdef PTW_PTE_CACHE_EN
    localparam int unsigned IdxW = $clog2(CACHE_ENTRIES);
    localparam int unsigned TagW = 61 - IdxW;

    logic [CACHE_ENTRIES-1:0] valid_q, valid_d;
    logic [TagW-1:0]          tag_q [CACHE_ENTRIES];
    logic [63:0]              pte_q [CACHE_ENTRIES];
    logic [IdxW-1:0]          idx;
    logic [TagW-1:0]          tag;
    logic                     fill;

    assign flush_in = pte_io.flush;
    assign idx      = req_addr_q[3 +: IdxW];
    assign tag      = req_addr_q[63 -: TagW];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign hit_pte  = pte_q[idx];
    // Only valid PTEs are cached; a flush anywhere in the transaction blocks the fill.
    assign fill     = (state_q == StBus) && pte_io.bus_data_ok && !nofill_q && !flush_in &&
                      pte_io.bus_data[0];

    always_comb begin
        valid_d = valid_q;
        if (fill) begin
            valid_d[idx] = 1'b1;
        end
        if (flush_in) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx] <= tag;
            pte_q[idx] <= pte_io.bus_data;
        end
    end
`else
    logic unused_cfg;

    assign flush_in   = 1'b0;
    assign hit        = 1'b0;
    assign hit_pte    = '0;
    assign unused_cfg = pte_io.flush ^ nofill_q;
`endif

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        mem_data_d = mem_data_q;
        drop_d     = drop_q;
        nofill_d   = nofill_q;
        unique case (state_q)
            StIdle: begin
                if (pte_io.mem_req) begin
                    req_addr_d = {pte_io.mem_addr[63:3], 3'b000};
                    drop_d     = 1'b0;
                    nofill_d   = 1'b0;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                if (flush_in) begin
                    nofill_d = 1'b1;
                end
                if (!pte_io.mem_req) begin
                    drop_d = 1'b1;
                end
                if (hit && !flush_in) begin
                    if (pte_io.mem_req) begin
                        mem_data_d = hit_pte;
                        state_d    = StResp;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    state_d = StBus;
                end
            end
            StBus: begin
                if (flush_in) begin
                    nofill_d = 1'b1;
                end
                if (!pte_io.mem_req) begin
                    drop_d = 1'b1;
                end
                if (pte_io.bus_data_ok) begin
                    mem_data_d = pte_io.bus_data;
                    // A request withdrawn on the completion cycle is also abandoned.
                    state_d    = (drop_q || !pte_io.mem_req) ? StIdle : StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            mem_data_q <= '0;
            drop_q     <= 1'b0;
            nofill_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            mem_data_q <= mem_data_d;
            drop_q     <= drop_d;
            nofill_q   <= nofill_d;
        end
    end

    assign pte_io.mem_data       = mem_data_q;
    assign pte_io.mem_data_valid = (state_q == StResp);
    assign pte_io.bus_valid      = (state_q == StBus);
    assign pte_io.bus_addr       = (state_q == StBus) ? req_addr_q : '0;
    assign pte_io.bus_size       = 3'b011;
    assign pte_io.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Bench for ptw_mem_responder: directed plan steps then randomized reads against a cache model.
// Expectations follow PTW_PTE_CACHE_EN the same way the design build does.
module tb_ptw_mem_responder;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

`ifdef PTW_PTE_CACHE_EN
    localparam bit CacheOn = 1'b1;
`else
    localparam bit CacheOn = 1'b0;
`endif

    ptw_mem_responder_if pte_if ();

    ptw_mem_responder #(
        .CACHE_ENTRIES(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pte_io (pte_if.slave)
    );

    always #5 clk = ~clk;

    // Model: at most one cached line per index addr[4:3], keyed by full aligned address.
    bit          m_has [int];
    logic [63:0] m_addr[int];
    logic [63:0] m_pte [int];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_has.delete();
        m_addr.delete();
        m_pte.delete();
    endtask

    task automatic m_lookup(input logic [63:0] a, output bit h, output logic [63:0] p);
        int i;
        i = int'(a[4:3]);
        h = CacheOn && m_has.exists(i) && (m_addr[i] == a);
        p = h ? m_pte[i] : 64'd0;
    endtask

    task automatic do_flush();
        pte_if.mem_req = 1'b0;
        pte_if.flush   = 1'b1;
        tick();
        pte_if.flush   = 1'b0;
        tick();
        m_clear();
    endtask

    // Starts in IDLE; flush_k/drop_k are BUS-cycle indices (-1 = never).
    task automatic do_read(input logic [63:0] addr, input int lat, input logic [63:0] pte,
                           input int flush_k, input int drop_k, input bit b2b);
        logic [63:0] al;
        logic [63:0] mp;
        bit          h;
        bit          fl;
        bit          dropped;
        al = {addr[63:3], 3'b000};
        m_lookup(al, h, mp);
        pte_if.mem_req  = 1'b1;
        pte_if.mem_addr = addr;
        tick();
        chk("lookup_busy", 64'(pte_if.busy), 64'd1);
        chk("lookup_valid", 64'(pte_if.mem_data_valid), 64'd0);
        pte_if.mem_addr = {$urandom, $urandom};
        if (h) begin
            tick();
            chk("hit_valid", 64'(pte_if.mem_data_valid), 64'd1);
            chk("hit_data", pte_if.mem_data, mp);
            chk("hit_no_bus", 64'(pte_if.bus_valid), 64'd0);
            pte_if.mem_req = b2b;
            tick();
            chk("hit_after_valid", 64'(pte_if.mem_data_valid), 64'd0);
            chk("hit_after_busy", 64'(pte_if.busy), 64'd0);
            return;
        end
        tick();
        fl = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk("bus_valid", 64'(pte_if.bus_valid), 64'd1);
            chk("bus_addr", pte_if.bus_addr, al);
            chk("bus_size", 64'(pte_if.bus_size), 64'd3);
            chk("bus_no_resp", 64'(pte_if.mem_data_valid), 64'd0);
            if (k == flush_k) begin
                pte_if.flush = 1'b1;
                fl = 1'b1;
            end
            if (k == drop_k) pte_if.mem_req = 1'b0;
            pte_if.mem_addr    = {$urandom, $urandom};
            pte_if.bus_data_ok = (k == lat - 1);
            pte_if.bus_data    = (k == lat - 1) ? pte : {$urandom, $urandom};
            tick();
            pte_if.flush       = 1'b0;
            pte_if.bus_data_ok = 1'b0;
        end
        if (fl) m_clear();
        if (CacheOn && pte[0] && !fl) begin
            m_has[int'(al[4:3])]  = 1'b1;
            m_addr[int'(al[4:3])] = al;
            m_pte[int'(al[4:3])]  = pte;
        end
        dropped = (drop_k >= 0) && (drop_k < lat);
        if (dropped) begin
            chk("drop_no_valid", 64'(pte_if.mem_data_valid), 64'd0);
            chk("drop_busy_low", 64'(pte_if.busy), 64'd0);
            chk("drop_bus_low", 64'(pte_if.bus_valid), 64'd0);
        end else begin
            chk("miss_valid", 64'(pte_if.mem_data_valid), 64'd1);
            chk("miss_data", pte_if.mem_data, pte);
            chk("miss_bus_low", 64'(pte_if.bus_valid), 64'd0);
            pte_if.mem_req = b2b;
            tick();
            chk("miss_after_valid", 64'(pte_if.mem_data_valid), 64'd0);
            chk("miss_after_busy", 64'(pte_if.busy), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] pool [6];
        logic [63:0] a;
        logic [63:0] p;
        int          lat;
        int          fk;
        int          dk;

        pool[0] = 64'h8000_1000;
        pool[1] = 64'h8000_1008;
        pool[2] = 64'h8000_1010;
        pool[3] = 64'h8000_1018;
        pool[4] = 64'h8000_1020;
        pool[5] = 64'h9000_0008;

        reset              = 1'b1;
        pte_if.mem_req     = 1'b0;
        pte_if.mem_addr    = '0;
        pte_if.flush       = 1'b0;
        pte_if.bus_data_ok = 1'b0;
        pte_if.bus_data    = '0;
        tick();
        tick();
        chk("rst_valid", 64'(pte_if.mem_data_valid), 64'd0);
        chk("rst_data", pte_if.mem_data, 64'd0);
        chk("rst_bus_valid", 64'(pte_if.bus_valid), 64'd0);
        chk("rst_bus_addr", pte_if.bus_addr, 64'd0);
        chk("rst_busy", 64'(pte_if.busy), 64'd0);
        chk("rst_bus_size", 64'(pte_if.bus_size), 64'd3);
        reset = 1'b0;
        tick();
        m_clear();

        do_read(64'h8000_1007, 3, 64'h0000_0000_2000_0401, -1, -1, 1'b0);
        do_read(64'h8000_1000, 3, 64'h0000_0000_2000_0401, -1, -1, 1'b0);
        do_flush();
        do_read(64'h8000_1000, 2, 64'h0000_0000_2000_0401, -1, -1, 1'b0);
        do_flush();
        do_read(64'h8000_1000, 3, 64'h0000_0000_2000_0401, 1, -1, 1'b0);
        do_read(64'h8000_1000, 2, 64'h0000_0000_2000_0401, -1, -1, 1'b0);
        do_read(64'h8000_1018, 4, 64'h0000_0000_3000_0c01, -1, 1, 1'b0);
        do_read(64'h8000_1018, 2, 64'h0000_0000_3000_0c01, -1, -1, 1'b0);
        do_read(64'h8000_2000, 2, 64'h0, -1, -1, 1'b0);
        do_read(64'h8000_2000, 2, 64'h0, -1, -1, 1'b0);

        // Reset while the bus read is outstanding, then a stale completion.
        pte_if.mem_req  = 1'b1;
        pte_if.mem_addr = 64'h8000_3008;
        tick();
        tick();
        chk("pre_rst_bus_valid", 64'(pte_if.bus_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_bus_valid", 64'(pte_if.bus_valid), 64'd0);
        chk("midrst_busy", 64'(pte_if.busy), 64'd0);
        chk("midrst_data", pte_if.mem_data, 64'd0);
        m_clear();
        pte_if.mem_req     = 1'b0;
        pte_if.bus_data_ok = 1'b1;
        pte_if.bus_data    = 64'h0000_0000_4000_0001;
        tick();
        pte_if.bus_data_ok = 1'b0;
        chk("late_ok_valid", 64'(pte_if.mem_data_valid), 64'd0);
        chk("late_ok_busy", 64'(pte_if.busy), 64'd0);
        do_read(64'h8000_3008, 2, 64'h0000_0000_5000_0001, -1, -1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            a      = pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 7));
            p      = {$urandom, $urandom};
            p[0]   = ($urandom_range(0, 3) != 0);
            lat    = $urandom_range(1, 4);
            fk     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat - 1) : -1;
            dk     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat - 1) : -1;
            if ($urandom_range(0, 9) == 0) do_flush();
            do_read(a, lat, p, fk, dk, 1'($urandom_range(0, 1)));
        end
        pte_if.mem_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
